// File: rtl/bcd_seg_if.sv
// bcd_seg_if: bus between the counter chain (master) and the display
// scanner (slave).
//   bcd_in    : packed BCD digits, digit k at [4k+3:4k]
//   load      : capture strobe for bcd_in
//   seg       : 7-segment bus {g,f,e,d,c,b,a}
//   an        : one-hot digit enables
//   scan_tick : one-cycle pulse when the scan advances
interface bcd_seg_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                load;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                scan_tick;

  modport master (output bcd_in, load, input seg, an, scan_tick);
  modport slave  (input bcd_in, load, output seg, an, scan_tick);
endinterface

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: shadows a packed BCD vector on load and time-multiplexes
// the digits onto one 7-segment bus with one-hot digit enables.
// Ports:
//   clk_i   : system clock, all state on posedge
//   reset_i : synchronous active-high reset
//   bus     : bcd_seg_if.slave (bcd_in/load in; seg/an/scan_tick out, all registered)
// Parameters: DIGITS (1-8), SCAN_DIV (>=2, cycles per slot), ACTIVE_LOW.
// Optional: define LZ_BLANK_EN to blank leading zero digits (digit 0 never blanked).
module bcd_seg_scanner #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  bcd_seg_if.slave   bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // Off level per polarity; XOR with it turns active-high values into pin levels.
  localparam logic [6:0]        SEG_OFF  = {7{(ACTIVE_LOW != 0)}};
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{(ACTIVE_LOW != 0)}};

  logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   tick_q, tick_d;
  logic                   term;
  logic [6:0]             seg_raw;
  logic [DIGITS-1:0]      an_raw;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'h3F;
      4'd1:    dec7 = 7'h06;
      4'd2:    dec7 = 7'h5B;
      4'd3:    dec7 = 7'h4F;
      4'd4:    dec7 = 7'h66;
      4'd5:    dec7 = 7'h6D;
      4'd6:    dec7 = 7'h7D;
      4'd7:    dec7 = 7'h07;
      4'd8:    dec7 = 7'h7F;
      4'd9:    dec7 = 7'h6F;
      default: dec7 = 7'h40; // non-BCD codes show a dash
    endcase
  endfunction

`ifdef LZ_BLANK_EN
  // blank[k]: digit k and every digit above it are zero.
  logic [DIGITS-1:0] blank;
  assign blank[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_lz
    assign blank[k] = ~|shadow_q[DIGITS-1:k];
  end
`endif

  always_comb begin
    term     = (presc_q == PRE_LAST);
    presc_d  = term ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (term) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    tick_d   = term;
    shadow_d = bus.load ? bus.bcd_in : shadow_q;

    // Outputs come from the pre-edge idx/shadow, giving one cycle of latency.
    seg_raw        = dec7(shadow_q[idx_q]);
    an_raw         = '0;
    an_raw[idx_q]  = 1'b1;
`ifdef LZ_BLANK_EN
    if (blank[idx_q]) begin
      seg_raw = '0;
      an_raw  = '0;
    end
`endif
    seg_d = seg_raw ^ SEG_OFF;
    an_d  = an_raw ^ AN_OFF;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      tick_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      tick_q   <= tick_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.scan_tick = tick_q;
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner: two instances (active-high and active-low) share
// stimulus; outputs are compared to constants and to a cycle-count model.
module tb_bcd_seg_scanner;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = '0;
  logic        load = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bcd_seg_if #(.DIGITS(DIGITS)) if_hi ();
  bcd_seg_if #(.DIGITS(DIGITS)) if_lo ();
  assign if_hi.bcd_in = bcd;
  assign if_hi.load   = load;
  assign if_lo.bcd_in = bcd;
  assign if_lo.load   = load;

  bcd_seg_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)) u_hi (
    .clk_i(clk), .reset_i(rst), .bus(if_hi.slave));
  bcd_seg_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) u_lo (
    .clk_i(clk), .reset_i(rst), .bus(if_lo.slave));

  // Reference model: edge count since reset gives slot = (n / SCAN_DIV) % DIGITS.
  localparam logic [6:0] SEGTAB [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int unsigned n_q;
  logic [15:0] m_shadow;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_tick;

  function automatic logic [10:0] model_out(input logic [15:0] sh, input int unsigned n);
    int unsigned k;
    logic [6:0]  s;
    logic [3:0]  a;
    k = (n / SCAN_DIV) % DIGITS;
    s = SEGTAB[(sh >> (4 * k)) & 16'hF];
    a = 4'(1 << k);
`ifdef LZ_BLANK_EN
    if (k > 0 && (sh >> (4 * k)) == 16'h0) begin
      s = '0;
      a = '0;
    end
`endif
    return {a, s};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n_q <= 0; m_shadow <= '0; exp_seg <= '0; exp_an <= '0; exp_tick <= 1'b0;
    end else begin
      {exp_an, exp_seg} <= model_out(m_shadow, n_q);
      m_shadow <= load ? bcd : m_shadow;
      n_q      <= n_q + 1;
      exp_tick <= ((n_q + 1) % SCAN_DIV) == 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for scan slot", nm);
  endtask

  // One clock; compare both instances to the model at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("mdl_seg_hi",  {25'b0, if_hi.seg},       {25'b0, exp_seg});
    chk("mdl_an_hi",   {28'b0, if_hi.an},        {28'b0, exp_an});
    chk("mdl_tick_hi", {31'b0, if_hi.scan_tick}, {31'b0, exp_tick});
    chk("mdl_seg_lo",  {25'b0, if_lo.seg},       {25'b0, ~exp_seg});
    chk("mdl_an_lo",   {28'b0, if_lo.an},        {28'b0, ~exp_an});
    chk("mdl_tick_lo", {31'b0, if_lo.scan_tick}, {31'b0, exp_tick});
  endtask

  // Step until active-low an equals (eq=1) or differs from (eq=0) v.
  task automatic wait_lo(input logic [3:0] v, input bit eq, input string nm);
    int i;
    for (i = 0; i < 40; i++) begin
      if ((if_lo.an == v) == eq) break;
      step();
    end
    if (i == 40) timeout(nm);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; bcd = v;
    step();
    load = 1'b0;
    step();
  endtask

  typedef struct {
    logic [15:0] word;
    int          dig;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs [$];

  initial begin
    vecs = '{
      '{16'h1234, 0, 7'h66}, '{16'h1234, 1, 7'h4F}, '{16'h1234, 2, 7'h5B}, '{16'h1234, 3, 7'h06},
      '{16'hFA90, 0, 7'h3F}, '{16'hFA90, 1, 7'h6F}, '{16'hFA90, 2, 7'h40}, '{16'hFA90, 3, 7'h40},
      '{16'h8888, 2, 7'h7F}, '{16'h7654, 3, 7'h07}, '{16'h7654, 2, 7'h7D}};

    // Reset release
    repeat (3) begin
      step();
      chk("rst_seg",    {25'b0, if_hi.seg},       32'h00);
      chk("rst_an",     {28'b0, if_hi.an},        32'h0);
      chk("rst_tick",   {31'b0, if_hi.scan_tick}, 32'h0);
      chk("rst_seg_lo", {25'b0, if_lo.seg},       32'h7F);
      chk("rst_an_lo",  {28'b0, if_lo.an},        32'hF);
    end
    rst = 1'b0;
    step();
    chk("rel_an",  {28'b0, if_hi.an},  32'h1);
    chk("rel_seg", {25'b0, if_hi.seg}, 32'h3F);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("first_tick", {31'b0, if_hi.scan_tick}, {31'b0, (i == SCAN_DIV)});
    end

    // Load coincident with terminal count on digit 0
    rst = 1'b1; step(); rst = 1'b0;
    repeat (3) step();
    chk("lt_pre_seg", {25'b0, if_hi.seg}, 32'h3F);
    load = 1'b1; bcd = 16'h8888;
    step();
    load = 1'b0;
    chk("lt_edge_seg",  {25'b0, if_hi.seg},       32'h3F);
    chk("lt_edge_tick", {31'b0, if_hi.scan_tick}, 32'h1);
    step();
    chk("lt_next_an",  {28'b0, if_hi.an},  32'h2);
    chk("lt_next_seg", {25'b0, if_hi.seg}, 32'h7F);

    // Table: decode per digit slot
    foreach (vecs[i]) begin
      do_load(vecs[i].word);
      wait_lo(~(4'(1 << vecs[i].dig)), 1'b1, "tbl_wait");
      chk($sformatf("tbl_seg_%0h_d%0d", vecs[i].word, vecs[i].dig),
          {25'b0, if_hi.seg}, {25'b0, vecs[i].seg});
    end

    // Reset mid-slot: idx=2, prescaler=2 after 10 edges
    rst = 1'b1; step(); rst = 1'b0;
    load = 1'b1; bcd = 16'h5555;
    step();
    load = 1'b0;
    repeat (9) step();
    chk("mid_an_pre", {28'b0, if_hi.an}, 32'h4);
    rst = 1'b1;
    step();
    chk("mid_rst_seg",    {25'b0, if_hi.seg}, 32'h00);
    chk("mid_rst_an",     {28'b0, if_hi.an},  32'h0);
    chk("mid_rst_seg_lo", {25'b0, if_lo.seg}, 32'h7F);
    chk("mid_rst_an_lo",  {28'b0, if_lo.an},  32'hF);
    rst = 1'b0;
    step();
    chk("mid_rel_an",  {28'b0, if_hi.an},  32'h1);
    chk("mid_rel_seg", {25'b0, if_hi.seg}, 32'h3F);

    // Polarity and leading zeros on the active-low instance
    do_load(16'h0050);
    wait_lo(4'b1110, 1'b0, "lz_leave0");
    wait_lo(4'b1110, 1'b1, "lz_enter0");
    chk("lz_d0_seg", {25'b0, if_lo.seg}, 32'h40);
    repeat (SCAN_DIV) step();
    chk("lz_d1_seg", {25'b0, if_lo.seg}, 32'h12);
    chk("lz_d1_an",  {28'b0, if_lo.an},  32'hD);
    repeat (SCAN_DIV) step();
`ifdef LZ_BLANK_EN
    chk("lz_d2_seg", {25'b0, if_lo.seg}, 32'h7F);
    chk("lz_d2_an",  {28'b0, if_lo.an},  32'hF);
`else
    chk("lz_d2_seg", {25'b0, if_lo.seg}, 32'h40);
    chk("lz_d2_an",  {28'b0, if_lo.an},  32'hB);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 7) == 0);
      bcd  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) bcd[15:12] = 4'h0;
      if ($urandom_range(0, 2) == 0) bcd[11:8]  = 4'h0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scanner.md
Name: bcd_seg_scanner

Overview:
- Downstream display stage for the synchronous decade counters (4-bit BCD, 0-9 per digit).
- Captures a packed vector of BCD digits on a load strobe and holds it in a shadow register.
- Time-multiplexes the digits onto a single 7-segment bus with one-hot digit enables, decoding BCD to segments.
- Sits between the counter chain and the board display pins.

Parameters:
- DIGITS, 4: number of BCD digits scanned; legal range 1-8.
- SCAN_DIV, 50000: clk cycles per digit slot; legal minimum 2.
- ACTIVE_LOW, 1: 1 means seg and an are driven active-low; 0 means active-high.

Ports:
- clk  input  1  single system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- bcd_in  input  4*DIGITS  packed digits; digit k is bits [4k+3:4k]; digit 0 is least significant.
- load  input  1  when high at posedge, bcd_in is captured into the shadow register.
- seg  output  7  segment bus, bit order {g,f,e,d,c,b,a}; registered.
- an  output  DIGITS  one-hot digit enable, bit k selects digit k; registered.
- scan_tick  output  1  one-cycle pulse on the cycle the digit index advances; registered.

Behaviour:
- Reset, while reset is high at posedge:
  - shadow = 0, prescaler = 0, idx = 0, scan_tick = 0.
  - seg = all segments off; an = all digits off, where "off" is the inactive level per ACTIVE_LOW.
  - reset has priority over load and tick. Reset mid-scan aborts the slot; scanning restarts at digit 0.
- Load:
  - load=1 at posedge copies bcd_in into shadow. There is no other path into shadow.
  - With load=0, shadow holds.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - Terminal count is prescaler==SCAN_DIV-1. On that edge:
    - idx <= (idx==DIGITS-1) ? 0 : idx+1.
    - scan_tick <= 1 for exactly one cycle.
  - On all other edges, scan_tick <= 0.
  - Tick period is exactly SCAN_DIV cycles; the first tick occurs SCAN_DIV cycles after reset deassertion.
- Output registers, updated every non-reset edge from the current (pre-edge) idx and shadow:
  - an <= one-hot(idx).
  - seg <= decode(shadow digit idx).
  - Both pass through the polarity stage.
  - Latency: seg/an reflect an idx change or a load 1 cycle later.
  - First non-reset edge after reset: an selects digit 0 and seg shows decode(0).
- Decode table, active-high values before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Codes 10-15 give 40, which is segment g only (dash).
- Simultaneous load and tick: both take effect at the same edge. The next edge shows the new shadow value on the new idx.
- Exactly one bit of an is active in every non-reset cycle after the first, unless blanked by the optional feature.
- No combinational path from any input to any output.

Optional Feature:
- Macro LZ_BLANK_EN.
- Defined (leading-zero blanking):
  - Digit k>0 is blanked when it and every higher digit equal 0 in shadow.
  - A blanked digit drives seg all off and an all off for its slot.
  - Digit 0 is never blanked.
  - Blanking is evaluated from shadow with the same 1-cycle output latency.
- Undefined: every digit is displayed, including leading zeros; the blanking logic is absent from the netlist.

Test Plan (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0 unless stated):
- Reset release:
  - Stimulus: reset held high 3 cycles, then released.
  - Required: seg=00, an=0000 and scan_tick=0 during reset. The next cycle gives an=0001, seg=3F. The first scan_tick comes 4 cycles after release.
- Full scan:
  - Stimulus: load bcd_in=16'h1234.
  - Required: an sequences 0001,0010,0100,1000,0001 with 4 cycles per slot. seg values are 66,4F,5B,06 respectively.
- Invalid codes:
  - Stimulus: load 16'hFA90.
  - Required: digit 0 gives 3F, digit 1 gives 6F, digits 2 and 3 give 40.
- Load coincident with tick:
  - Stimulus: load 16'h8888 on the terminal-count edge while digit 0 is showing 3F.
  - Required: the next edge gives an=0010, seg=7F; no stale value appears.
- Reset mid-slot:
  - Stimulus: assert reset while idx=2 with prescaler at 2.
  - Required: outputs go all off. After release, the scan restarts at an=0001, shadow reads 0, seg=3F.
- Leading-zero blanking and polarity:
  - Stimulus: LZ_BLANK_EN defined, ACTIVE_LOW=1, load 16'h0050.
  - Required:
    - Digit 0 gives seg=~3F=40 with an=1110.
    - Digit 1 gives seg=~6D=12.
    - Digits 2 and 3 give seg=7F and an=1111 (blanked).
